// File: rtl/mul_div_unit_pkg.sv
// Shared constants and types for the iterative multiply/divide unit.
// Holds the operand/result width, register-index width, op encodings and FSM states.
// No logic lives here; the package is imported by the interface users and the core.
package mul_div_unit_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 4;

    // op[0] selects the high half of the shift register, op[1] selects divide.
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the issue logic and the multiply/divide unit.
// Request side: start, op, src1_data, src2_data, dst. Result side: busy, wrt_en, dst_out, dst_data.
// No backpressure signal: the requester watches busy; start is only honoured when idle.
interface mul_div_unit_if #(
    parameter int DATA_W = mul_div_unit_pkg::DATA_W,
    parameter int REG_W  = mul_div_unit_pkg::REG_W
);

    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src1_data;
    logic [DATA_W-1:0] src2_data;
    logic [REG_W-1:0]  dst;
    logic              busy;
    logic              wrt_en;
    logic [REG_W-1:0]  dst_out;
    logic [DATA_W-1:0] dst_data;

    // Issuing side (decode / register-file read stage).
    modport master (
        output start, op, src1_data, src2_data, dst,
        input  busy, wrt_en, dst_out, dst_data
    );

    // The arithmetic unit.
    modport slave (
        input  start, op, src1_data, src2_data, dst,
        output busy, wrt_en, dst_out, dst_data
    );

endinterface

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU, one bit per clock on a shared shift register.
// Latency: start sampled at E0, wrt_en strobes E32..E33; back-to-back issue every 34 cycles.
// Backpressure: none queued; start is ignored while busy (CALC/DONE), requester must retry.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries request and result.
module mul_div_unit #(
    parameter int DATA_W = mul_div_unit_pkg::DATA_W,
    parameter int REG_W  = mul_div_unit_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    mul_div_unit_if.slave     bus
);

    import mul_div_unit_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);
    localparam int ACC_W = 2 * DATA_W;

    state_e            state_q,  state_d;
    op_e               op_q,     op_d;
    logic [DATA_W-1:0] opb_q,    opb_d;
    logic [ACC_W-1:0]  acc_q,    acc_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [REG_W-1:0]  dst_q,    dst_d;
    logic [DATA_W-1:0] res_q,    res_d;
    logic              wrt_en_q, wrt_en_d;
    logic              busy_q,   busy_d;

    logic              is_div;
    logic [DATA_W:0]   add_a;
    logic [DATA_W:0]   add_b;
    logic [DATA_W:0]   add_s;
    logic [ACC_W-1:0]  acc_step;
    logic [DATA_W-1:0] result;

    // One iteration of the shared datapath.
    // Multiply: acc = {partial product, multiplier}; conditional add into the top half,
    //   then shift right so the carry out lands in the top bit.
    // Divide: acc = {partial remainder, dividend/quotient}; the shifted-left remainder is
    //   the top DATA_W+1 bits, so subtracting the divisor from acc[ACC_W-1:DATA_W-1] is the
    //   shift-then-subtract. The remainder before the shift is below the divisor, so the
    //   difference always fits DATA_W+1 signed bits and its MSB is a clean borrow flag.
    //   With a zero divisor there is never a borrow: quotient all ones, remainder = dividend.
    always_comb begin
        is_div = op_q[1];
        add_a  = is_div ? acc_q[ACC_W-1:DATA_W-1] : {1'b0, acc_q[ACC_W-1:DATA_W]};
        add_b  = is_div ? ~{1'b0, opb_q} : {1'b0, opb_q};
        add_s  = add_a + add_b + {{DATA_W{1'b0}}, is_div};

        if (is_div) begin
            if (add_s[DATA_W]) begin
                acc_step = {acc_q[ACC_W-2:0], 1'b0};
            end else begin
                acc_step = {add_s[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            end
        end else begin
            if (acc_q[0]) begin
                acc_step = {add_s, acc_q[DATA_W-1:1]};
            end else begin
                acc_step = {1'b0, acc_q[ACC_W-1:1]};
            end
        end

        // MULHU/REMU live in the high half, MUL/DIVU in the low half.
        result = op_q[0] ? acc_step[ACC_W-1:DATA_W] : acc_step[DATA_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dst_d    = dst_q;
        res_d    = res_q;
        wrt_en_d = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CALC;
                    op_d    = op_e'(bus.op);
                    opb_d   = bus.src2_data;
                    acc_d   = {{DATA_W{1'b0}}, bus.src1_data};
                    cnt_d   = '0;
                    dst_d   = bus.dst;
                    busy_d  = 1'b1;
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                // Last iteration: capture the finished word alongside the strobe so
                // dst_data is valid in the same cycle wrt_en is high.
                if (cnt_q == {CNT_W{1'b1}}) begin
                    state_d  = ST_DONE;
                    wrt_en_d = 1'b1;
                    res_d    = result;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dst_q    <= '0;
            res_q    <= '0;
            wrt_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
            res_q    <= res_d;
            wrt_en_q <= wrt_en_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.wrt_en   = wrt_en_q;
    assign bus.dst_out  = dst_q;
    assign bus.dst_data = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: scoreboard of expected (dst, data, strobe edge).
// Expected values come from a behavioural model using native * / % operators.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_mul_div_unit;

    typedef struct {
        logic [3:0]  dst;
        logic [31:0] data;
        int          at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [31:0] last_data = '0;

    mul_div_unit_if #(.DATA_W(32), .REG_W(4)) bus ();

    mul_div_unit #(.DATA_W(32), .REG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Result monitor: every strobe must match the oldest expectation, on its edge.
    always @(negedge clk) begin
        if (bus.wrt_en) begin
            check("strobe_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_edge", cyc, e.at_edge);
                check("dst_out", bus.dst_out, e.dst);
                check("dst_data", bus.dst_data, e.data);
                last_data = e.data;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance (E0).
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, output int e0);
        exp_t e;
        bus.start = 1'b1;
        bus.op = op;
        bus.src1_data = a;
        bus.src2_data = b;
        bus.dst = d;
        @(posedge clk);
        #1;
        e0 = cyc;
        e.dst = d;
        e.data = model(op, a, b);
        e.at_edge = e0 + 32;
        sb.push_back(e);
        check("busy_after_start", bus.busy, 1);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 100);
        check("idle_reached", bus.busy, 0);
        check("data_hold", bus.dst_data, last_data);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d);
        int e0;
        issue(op, a, b, d, e0);
        wait_idle();
    endtask

    initial begin
        int   e0;
        int   e1;
        exp_t e;

        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.src1_data = '0;
        bus.src2_data = '0;
        bus.dst = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_wrt_en", bus.wrt_en, 0);
        check("rst_dst_out", bus.dst_out, 0);
        check("rst_dst_data", bus.dst_data, 0);

        // First start on the first edge with rst low.
        rst = 1'b0;
        run_op(2'b00, 32'd7, 32'd6, 4'd3);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
        run_op(2'b10, 32'd100, 32'd7, 4'd4);
        run_op(2'b11, 32'd100, 32'd7, 4'd5);
        run_op(2'b10, 32'h1234, 32'd0, 4'd6);
        run_op(2'b11, 32'h1234, 32'd0, 4'd7);

        for (int i = 0; i < 6; i++) begin
            run_op(2'(i % 4), $urandom, (i == 5) ? 32'd1 : ($urandom >> (i * 4)), 4'(i + 8));
        end

        // start pulse and operand changes during CALC must be ignored.
        issue(2'b00, 32'd5, 32'd5, 4'd9, e0);
        while (cyc < e0 + 9) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b10;
        bus.src1_data = 32'd99;
        bus.src2_data = 32'd3;
        bus.dst = 4'd12;
        @(negedge clk);
        bus.start = 1'b0;
        bus.src1_data = 32'd1234;
        bus.src2_data = 32'd77;
        wait_idle();

        // Reset at E15 aborts a divide; a fresh start at E17 completes at E49.
        issue(2'b10, 32'd1000, 32'd3, 4'd10, e0);
        while (cyc < e0 + 14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(sb.pop_back());
        last_data = '0;
        check("abort_busy", bus.busy, 0);
        check("abort_wrt_en", bus.wrt_en, 0);
        check("abort_dst_data", bus.dst_data, 0);
        check("abort_dst_out", bus.dst_out, 0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy_e16", bus.busy, 0);
        check("abort_wrt_en_e16", bus.wrt_en, 0);
        issue(2'b11, 32'd1000, 32'd3, 4'd11, e1);
        check("restart_edge", e1, e0 + 17);
        wait_idle();

        // Back-to-back with start held high: MUL at E0, DIVU accepted at E34.
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.src1_data = 32'd12345;
        bus.src2_data = 32'd678;
        bus.dst = 4'd13;
        @(posedge clk);
        #1;
        e0 = cyc;
        e.dst = 4'd13;
        e.data = model(2'b00, 32'd12345, 32'd678);
        e.at_edge = e0 + 32;
        sb.push_back(e);
        @(negedge clk);
        bus.op = 2'b10;
        bus.src1_data = 32'd1000;
        bus.src2_data = 32'd7;
        bus.dst = 4'd14;
        e.dst = 4'd14;
        e.data = model(2'b10, 32'd1000, 32'd7);
        e.at_edge = e0 + 66;
        sb.push_back(e);
        while (cyc < e0 + 34) @(negedge clk);
        check("b2b_second_accepted", bus.busy, 1);
        bus.start = 1'b0;
        wait_idle();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
